voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler for the 8-voice ADSR bank.
- Accepts serialized note-on/note-off events and assigns each note-on to a free voice, or retriggers the voice already holding that note.
- Drives per-voice gate, note and retrigger lines, plus a 3-bit voice select that steers the 1-to-8 gate demux.
- Sits between the note/key input stage and the per-voice envelope generators.

Parameters:
- VOICES, 8, number of voices; fixed at 8 to match the 3-bit select.
- NOTE_W, 7, note number width.
- AGE_W, 3, per-voice age counter width; saturates at 2^AGE_W-1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low
- ev_valid  input  1  event present
- ev_ready  output  1  block can accept an event
- ev_on  input  1  1 = note-on, 0 = note-off
- ev_note  input  NOTE_W  event note number
- gate  output  VOICES  per-voice gate level
- voice_notes  output  VOICES*NOTE_W  voice i note at [i*NOTE_W +: NOTE_W]
- trig  output  VOICES  one-cycle retrigger pulse per voice
- sel  output  3  index of last voice committed
- sel_valid  output  1  one-cycle pulse when sel is updated
- dropped  output  1  one-cycle pulse when a note-on is discarded

Behaviour:
- Reset (reset_n low at a clk edge):
  - gate, voice_notes, trig, sel, sel_valid, dropped and all ages go to 0.
  - FSM goes to IDLE; any in-flight event is discarded.
  - ev_ready is 0 while reset_n is low.
- Handshake: ev_ready = 1 only in IDLE with reset_n high. An event is accepted when ev_valid && ev_ready at a rising edge (cycle 0). ev_on and ev_note are latched.
- FSM:
  - IDLE -> SCAN on accept.
  - SCAN lasts exactly 8 cycles (cycles 1-8) and examines voice idx 0..7, one per cycle.
  - SCAN -> COMMIT after idx 7. COMMIT occupies cycle 9.
  - COMMIT -> IDLE. Outputs are visible and ev_ready is high in cycle 10.
  - Fixed latency 10 cycles; throughput 1 event per 10 cycles.
- SCAN bookkeeping:
  - match = lowest idx with gate=1 and note==ev_note.
  - free = lowest idx with gate=0.
  - oldest = busy voice with max age, lowest idx on ties.
  - off_mask = bitmask of all busy voices whose note matches ev_note.
- COMMIT, note-on, priority order:
  - (1) If match exists: retrigger that voice. Gate stays 1, trig[match]=1 for one cycle, age[match]=0.
  - (2) Else if free exists: write the note, gate=1, trig pulse, age=0.
  - (3) Else all voices are busy: handled per VOICE_STEAL_EN.
  - On every successful assign: every other busy voice's age increments, saturating at 2^AGE_W-1. sel = assigned idx; sel_valid pulses.
- COMMIT, note-off:
  - gate &= ~off_mask; ages of released voices reset to 0; voice_notes unchanged.
  - If off_mask is non-zero: sel = lowest set idx; sel_valid pulses. Otherwise no output change and no pulse.
- trig, sel_valid and dropped are high only in the cycle after COMMIT and 0 otherwise.
- Gate changes only at COMMIT.
- Event fields are sampled only at accept; changes while ev_ready=0 are ignored.
- Reset takes precedence over COMMIT when both occur in the same cycle.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with all 8 voices busy steals the oldest voice. Its note is overwritten, gate stays 1, trig pulses, age=0, sel = stolen idx, sel_valid pulses. dropped stays 0.
- Undefined: the event is discarded. dropped pulses for one cycle; gate, voice_notes, ages, sel and trig are unchanged; sel_valid stays 0.
- Age counters are still maintained either way.

Test Plan:
- Reset: hold reset_n low for 3 cycles with ev_valid=1 -> all outputs 0 and ev_ready=0 while low. After release, ev_ready=1 and no event is accepted during reset.
- Single note-on 60 at cycle 0 -> cycle 10: gate=8'b00000001, voice_notes[6:0]=60, trig=8'b00000001 for 1 cycle, sel=0 with sel_valid pulse. ev_ready is low in cycles 1-9.
- Note-on 60, 62, 64, then note-off 62 -> gate=8'b00000101 and sel=1. A following note-on 65 reuses voice 1: gate=8'b00000111.
- Note-on 60 twice -> gate stays 8'b00000001, trig[0] pulses twice, voice 1 never gated.
- Note-on 60..67 (all busy), then note-on 70 -> with VOICE_STEAL_EN: voice 0 note=70, trig[0] pulse, gate=8'hFF, dropped=0. Without it: dropped pulse, voice 0 note still 60, sel_valid=0.
- Reset_n low in cycle 4 of SCAN for note-on 60 -> gate=0, no trig, ev_ready=1 on the first cycle after release, and a new event completes normally.

Source files
------------

// File: rtl/voice_allocator.sv
//-----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice scheduler for the 8-voice ADSR bank. Serialized
// note-on/note-off events are accepted one at a time. Each event is handled
// in three phases: IDLE, then SCAN for 8 cycles (one voice per cycle), then
// COMMIT. Results become visible 10 cycles after accept.
//
// Optional feature:
//   VOICE_STEAL_EN - when defined, a note-on with every voice busy steals the
//                    oldest voice. When undefined, such a note-on is dropped
//                    and the dropped output pulses.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   ev_valid     event present
//   ev_ready     block can accept an event (IDLE and out of reset)
//   ev_on        1 = note-on, 0 = note-off
//   ev_note      event note number
//   gate         per-voice gate level
//   voice_notes  voice i note at [i*NOTE_W +: NOTE_W]
//   trig         one-cycle retrigger pulse per voice
//   sel          index of the last voice committed
//   sel_valid    one-cycle pulse when sel is updated
//   dropped      one-cycle pulse when a note-on is discarded
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int NOTE_W = 7,
  parameter int AGE_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_on,
  input  logic [NOTE_W-1:0]        ev_note,
  output logic [VOICES-1:0]        gate,
  output logic [VOICES*NOTE_W-1:0] voice_notes,
  output logic [VOICES-1:0]        trig,
  output logic [2:0]               sel,
  output logic                     sel_valid,
  output logic                     dropped
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t              state_reg;
  logic [2:0]          idx_reg;
  logic                on_reg;
  logic [NOTE_W-1:0]   note_reg;

  // Scan bookkeeping, rebuilt for every event.
  logic                match_found_reg;
  logic [2:0]          match_idx_reg;
  logic                free_found_reg;
  logic [2:0]          free_idx_reg;
  logic [VOICES-1:0]   off_mask_reg;
`ifdef VOICE_STEAL_EN
  logic                oldest_found_reg;
  logic [2:0]          oldest_idx_reg;
  logic [AGE_W-1:0]    oldest_age_reg;
`endif

  // Voice state and registered outputs.
  logic [VOICES-1:0]   gate_reg;
  logic [VOICES-1:0]   trig_reg;
  logic [NOTE_W-1:0]   note_mem_reg [VOICES];
  logic [AGE_W-1:0]    age_reg      [VOICES];
  logic [2:0]          sel_reg;
  logic                sel_valid_reg;
  logic                dropped_reg;

  // Commit decision for a note-on, derived from the scan results.
  logic                assign_en;
  logic [2:0]          assign_idx;
  logic                off_any;
  logic [2:0]          off_low;

  always_comb begin
    assign_en  = 1'b0;
    assign_idx = '0;
    if (match_found_reg) begin
      assign_en  = 1'b1;
      assign_idx = match_idx_reg;
    end else if (free_found_reg) begin
      assign_en  = 1'b1;
      assign_idx = free_idx_reg;
    end else begin
`ifdef VOICE_STEAL_EN
      assign_en  = oldest_found_reg;
      assign_idx = oldest_idx_reg;
`else
      assign_en  = 1'b0;
      assign_idx = '0;
`endif
    end
  end

  // Lowest released voice: walk downward so the lowest set bit wins.
  always_comb begin
    off_low = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (off_mask_reg[i]) off_low = i[2:0];
    end
  end

  assign off_any = |off_mask_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      on_reg          <= 1'b0;
      note_reg        <= '0;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
      off_mask_reg    <= '0;
`ifdef VOICE_STEAL_EN
      oldest_found_reg <= 1'b0;
      oldest_idx_reg   <= '0;
      oldest_age_reg   <= '0;
`endif
      gate_reg        <= '0;
      trig_reg        <= '0;
      sel_reg         <= '0;
      sel_valid_reg   <= 1'b0;
      dropped_reg     <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        note_mem_reg[i] <= '0;
        age_reg[i]      <= '0;
      end
    end else begin
      // Pulse outputs only live for the single cycle after COMMIT.
      trig_reg      <= '0;
      sel_valid_reg <= 1'b0;
      dropped_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (ev_valid) begin
            on_reg          <= ev_on;
            note_reg        <= ev_note;
            idx_reg         <= '0;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            off_mask_reg    <= '0;
`ifdef VOICE_STEAL_EN
            oldest_found_reg <= 1'b0;
            oldest_age_reg   <= '0;
`endif
            state_reg       <= SCAN;
          end
        end

        SCAN: begin
          if (gate_reg[idx_reg] && (note_mem_reg[idx_reg] == note_reg)) begin
            if (!match_found_reg) begin
              match_found_reg <= 1'b1;
              match_idx_reg   <= idx_reg;
            end
            off_mask_reg[idx_reg] <= 1'b1;
          end
          if (!gate_reg[idx_reg] && !free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= idx_reg;
          end
`ifdef VOICE_STEAL_EN
          // Strictly greater keeps the lowest index on equal ages.
          if (gate_reg[idx_reg] &&
              (!oldest_found_reg || (age_reg[idx_reg] > oldest_age_reg))) begin
            oldest_found_reg <= 1'b1;
            oldest_idx_reg   <= idx_reg;
            oldest_age_reg   <= age_reg[idx_reg];
          end
`endif
          if (idx_reg == 3'd7) state_reg <= COMMIT;
          else                 idx_reg   <= idx_reg + 3'd1;
        end

        COMMIT: begin
          state_reg <= IDLE;
          if (on_reg) begin
            if (assign_en) begin
              for (int i = 0; i < VOICES; i++) begin
                if (i[2:0] == assign_idx) begin
                  gate_reg[i]     <= 1'b1;
                  note_mem_reg[i] <= note_reg;
                  age_reg[i]      <= '0;
                  trig_reg[i]     <= 1'b1;
                end else if (gate_reg[i] && (age_reg[i] != AGE_MAX)) begin
                  age_reg[i] <= age_reg[i] + AGE_ONE;
                end
              end
              sel_reg       <= assign_idx;
              sel_valid_reg <= 1'b1;
            end else begin
              dropped_reg <= 1'b1;
            end
          end else begin
            gate_reg <= gate_reg & ~off_mask_reg;
            for (int i = 0; i < VOICES; i++) begin
              if (off_mask_reg[i]) age_reg[i] <= '0;
            end
            if (off_any) begin
              sel_reg       <= off_low;
              sel_valid_reg <= 1'b1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ev_ready  = (state_reg == IDLE) && reset_n;
  assign gate      = gate_reg;
  assign trig      = trig_reg;
  assign sel       = sel_reg;
  assign sel_valid = sel_valid_reg;
  assign dropped   = dropped_reg;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_notes
    assign voice_notes[gi*NOTE_W +: NOTE_W] = note_mem_reg[gi];
  end

endmodule

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [7:0]  gate;
  logic [55:0] voice_notes;
  logic [7:0]  trig;
  logic [2:0]  sel;
  logic        sel_valid;
  logic        dropped;

  always #5 clk = ~clk;

  voice_allocator #(.VOICES(8), .NOTE_W(7), .AGE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .gate(gate), .voice_notes(voice_notes),
    .trig(trig), .sel(sel), .sel_valid(sel_valid), .dropped(dropped)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: voice table plus the pulses expected after one event.
  bit         m_gate [8];
  int         m_note [8];
  int         m_age  [8];
  int         m_sel;
  logic [7:0] exp_trig;
  bit         exp_sv;
  bit         exp_drop;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
    m_sel = 0;
  endtask

  function automatic logic [7:0] model_gate_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_gate[i];
    return v;
  endfunction

  function automatic logic [55:0] model_notes_vec();
    logic [55:0] v;
    logic [6:0]  n;
    for (int i = 0; i < 8; i++) begin
      n = 7'(m_note[i]);
      v[i*7 +: 7] = n;
    end
    return v;
  endfunction

  task automatic model_apply(input bit on, input int n);
    int target;
    bit any;
    exp_trig = 8'h00; exp_sv = 0; exp_drop = 0;
    if (on) begin
      target = -1;
      for (int i = 0; i < 8; i++)
        if (target < 0 && m_gate[i] && m_note[i] == n) target = i;
      for (int i = 0; i < 8; i++)
        if (target < 0 && !m_gate[i]) target = i;
`ifdef VOICE_STEAL_EN
      if (target < 0) begin
        target = 0;
        for (int i = 1; i < 8; i++)
          if (m_age[i] > m_age[target]) target = i;
      end
`endif
      if (target < 0) begin
        exp_drop = 1;
      end else begin
        for (int i = 0; i < 8; i++)
          if (i != target && m_gate[i]) m_age[i] = (m_age[i] < 7) ? m_age[i] + 1 : 7;
        m_gate[target] = 1; m_note[target] = n; m_age[target] = 0;
        exp_trig[target] = 1'b1;
        m_sel = target; exp_sv = 1;
      end
    end else begin
      any = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_gate[i] && m_note[i] == n) begin
          m_gate[i] = 0; m_age[i] = 0;
          if (!any) m_sel = i;
          any = 1;
        end
      end
      exp_sv = any;
    end
  endtask

  // Drives one event and compares every output against the model.
  task automatic run_event(input bit on, input int note);
    logic [7:0] prev_gate;
    logic [2:0] exp_sel;
    int         busy_bad;
    int         waited;
    waited = 0;
    while (ev_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL ready_wait: ev_ready=%b required 1", ev_ready);
    else passes++;

    prev_gate = model_gate_vec();
    model_apply(on, note);
    exp_sel = 3'(m_sel);
    ev_valid = 1'b1; ev_on = on; ev_note = note[6:0];
    @(posedge clk);
    busy_bad = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (ev_ready !== 1'b0 || trig !== 8'h00 || sel_valid !== 1'b0 ||
          dropped !== 1'b0 || gate !== prev_gate) busy_bad++;
      // Junk on the event bus while busy must be ignored.
      ev_valid = 1'($urandom_range(0, 1));
      ev_on    = 1'($urandom_range(0, 1));
      ev_note  = 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    ev_valid = 1'b0;

    checks++;
    if (busy_bad !== 0) $display("FAIL busy_cycles: bad_cycles=%0d required 0", busy_bad);
    else passes++;
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL ready_after: ev_ready=%b required 1", ev_ready);
    else passes++;
    checks++;
    if (gate !== model_gate_vec()) $display("FAIL gate: got %b required %b", gate, model_gate_vec());
    else passes++;
    checks++;
    if (voice_notes !== model_notes_vec())
      $display("FAIL voice_notes: got %h required %h", voice_notes, model_notes_vec());
    else passes++;
    checks++;
    if (trig !== exp_trig) $display("FAIL trig: got %b required %b", trig, exp_trig);
    else passes++;
    checks++;
    if (sel !== exp_sel) $display("FAIL sel: got %0d required %0d", sel, exp_sel);
    else passes++;
    checks++;
    if (sel_valid !== exp_sv) $display("FAIL sel_valid: got %b required %b", sel_valid, exp_sv);
    else passes++;
    checks++;
    if (dropped !== exp_drop) $display("FAIL dropped: got %b required %b", dropped, exp_drop);
    else passes++;
    $display("evt on=%0d note=%0d gate=%b trig=%b sel=%0d sel_valid=%0b dropped=%0b",
             on, note, gate, trig, sel, sel_valid, dropped);

    @(negedge clk);
    checks++;
    if (trig !== 8'h00 || sel_valid !== 1'b0 || dropped !== 1'b0)
      $display("FAIL pulse_clear: trig=%b sel_valid=%b dropped=%b required 0", trig, sel_valid, dropped);
    else passes++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gate, voice_notes, trig, sel, sel_valid, dropped} !== '0)
      $display("FAIL reset_outputs: gate=%b notes=%h trig=%b sel=%0d sv=%b drop=%b required 0",
               gate, voice_notes, trig, sel, sel_valid, dropped);
    else passes++;
    checks++;
    if (ev_ready !== 1'b0) $display("FAIL reset_ready_low: ev_ready=%b required 0", ev_ready);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1; ev_valid = 1'b0;
    #1;
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL reset_ready_high: ev_ready=%b required 1", ev_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (gate !== 8'h00 || ev_ready !== 1'b1)
      $display("FAIL reset_no_accept: gate=%b ev_ready=%b required 00000000/1", gate, ev_ready);
    else passes++;
    model_reset();
  endtask

  task automatic test_single_note();
    run_event(1, 60);
    checks++;
    if (gate !== 8'b00000001 || voice_notes[6:0] !== 7'd60 || sel !== 3'd0)
      $display("FAIL single_note: gate=%b note0=%0d sel=%0d required 00000001/60/0",
               gate, voice_notes[6:0], sel);
    else passes++;
  endtask

  task automatic test_release_reuse();
    apply_reset();
    run_event(1, 60); run_event(1, 62); run_event(1, 64);
    run_event(0, 62);
    checks++;
    if (gate !== 8'b00000101 || sel !== 3'd1)
      $display("FAIL release: gate=%b sel=%0d required 00000101/1", gate, sel);
    else passes++;
    run_event(1, 65);
    checks++;
    if (gate !== 8'b00000111 || voice_notes[13:7] !== 7'd65)
      $display("FAIL reuse: gate=%b note1=%0d required 00000111/65", gate, voice_notes[13:7]);
    else passes++;
    run_event(0, 99);  // releases nothing
  endtask

  task automatic test_retrigger();
    apply_reset();
    run_event(1, 60);
    run_event(1, 60);
    checks++;
    if (gate !== 8'b00000001) $display("FAIL retrigger: gate=%b required 00000001", gate);
    else passes++;
  endtask

  task automatic test_all_busy();
    apply_reset();
    for (int n = 60; n <= 67; n++) run_event(1, n);
    run_event(1, 70);
    checks++;
`ifdef VOICE_STEAL_EN
    if (gate !== 8'hFF || voice_notes[6:0] !== 7'd70 || sel !== 3'd0)
      $display("FAIL steal: gate=%b note0=%0d sel=%0d required ff/70/0", gate, voice_notes[6:0], sel);
    else passes++;
`else
    if (gate !== 8'hFF || voice_notes[6:0] !== 7'd60 || sel !== 3'd7)
      $display("FAIL drop: gate=%b note0=%0d sel=%0d required ff/60/7", gate, voice_notes[6:0], sel);
    else passes++;
`endif
  endtask

  task automatic test_reset_mid_scan();
    int bad;
    apply_reset();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);   // now in cycle 4
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 8'h00 || trig !== 8'h00 || ev_ready !== 1'b0)
      $display("FAIL midscan_reset: gate=%b trig=%b ev_ready=%b required 0/0/0", gate, trig, ev_ready);
    else passes++;
    reset_n = 1'b1;
    #1;
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL midscan_ready: ev_ready=%b required 1", ev_ready);
    else passes++;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gate !== 8'h00 || trig !== 8'h00 || sel_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL midscan_no_commit: bad_cycles=%0d required 0", bad);
    else passes++;
    model_reset();
    run_event(1, 62);
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 40; t++)
      run_event(($urandom_range(0, 9) < 7), 60 + int'($urandom_range(0, 11)));
  endtask

  initial begin
    reset_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;
    test_reset();
    test_single_note();
    test_release_reuse();
    test_retrigger();
    test_all_busy();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
